// File: rtl/input_port_ctrl.sv
// Debounced switch-load port: synchronizes board switches, port select and load button,
// and emits one load strobe per accepted press. Optional INPUT_PORT_CTRL_COUNT_EN adds press_count.
module input_port_ctrl #(
  parameter int WIDTH           = 32,
  parameter int SW_WIDTH        = 9,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                port_sel,
  input  logic                load_btn,
  output logic [WIDTH-1:0]    in_data,
  output logic                inport_0_en,
  output logic                inport_1_en,
  output logic                busy
`ifdef INPUT_PORT_CTRL_COUNT_EN
  ,
  output logic [7:0]          press_count
`endif
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic                sel_meta_q, sel_meta_d, sel_sync_q, sel_sync_d;
  logic                btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                strobe;

  logic [WIDTH-1:0]    in_data_q, in_data_d;
  logic                en0_q, en0_d, en1_q, en1_d;

  always_comb begin
    sw_meta_d  = switches;
    sw_sync_d  = sw_meta_q;
    sel_meta_d = port_sel;
    sel_sync_d = sel_meta_q;
    btn_meta_d = load_btn;
    btn_sync_d = btn_meta_q;
  end

  // The counter is only meaningful inside the two wait states; it is cleared on entry to each.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strobe  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          strobe  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Data and strobe load on the same edge so in_data is already valid during the strobe cycle.
  always_comb begin
    in_data_d = strobe ? WIDTH'(sw_sync_q) : in_data_q;
    en0_d     = strobe & ~sel_sync_q;
    en1_d     = strobe & sel_sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sel_meta_q <= 1'b0;
      sel_sync_q <= 1'b0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_data_q  <= '0;
      en0_q      <= 1'b0;
      en1_q      <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      sel_meta_q <= sel_meta_d;
      sel_sync_q <= sel_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_data_q  <= in_data_d;
      en0_q      <= en0_d;
      en1_q      <= en1_d;
    end
  end

  assign in_data     = in_data_q;
  assign inport_0_en = en0_q;
  assign inport_1_en = en1_q;
  assign busy        = (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);

`ifdef INPUT_PORT_CTRL_COUNT_EN
  logic [7:0] press_count_q, press_count_d;

  always_comb begin
    press_count_d = strobe ? press_count_q + 8'd1 : press_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count_q <= 8'd0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count = press_count_q;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Self-checking bench for input_port_ctrl with DEBOUNCE_CYCLES=4.
// A scoreboard queue holds the strobe each accepted press should produce.
module tb_input_port_ctrl;

   typedef struct {
      logic        sel;
      logic [31:0] data;
   } expStrobe_t;

   logic        clk;
   logic        rst;
   logic [8:0]  switches;
   logic        port_sel;
   logic        load_btn;
   logic [31:0] in_data;
   logic        inport_0_en;
   logic        inport_1_en;
   logic        busy;
`ifdef INPUT_PORT_CTRL_COUNT_EN
   logic [7:0]  press_count;
`endif

   expStrobe_t  expQueue[$];
   int          testsRun    = 0;
   int          testsFailed = 0;
   int          strobeCount = 0;
   int          modelCount  = 0;
   int          strobeBefore;
   logic        prevStrobe  = 1'b0;
   logic        busySeen    = 1'b0;

   input_port_ctrl #(
      .WIDTH(32),
      .SW_WIDTH(9),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .switches(switches),
      .port_sel(port_sel),
      .load_btn(load_btn),
      .in_data(in_data),
      .inport_0_en(inport_0_en),
      .inport_1_en(inport_1_en),
      .busy(busy)
`ifdef INPUT_PORT_CTRL_COUNT_EN
      ,
      .press_count(press_count)
`endif
   );

   // Free-running 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay in one place
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive all raw inputs just after a rising edge
   task automatic applyStimulus(input logic [8:0] sw, input logic sel, input logic btn);
      @(posedge clk);
      #1;
      switches = sw;
      port_sel = sel;
      load_btn = btn;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   // A clean press long enough to be accepted, followed by a clean release back to IDLE
   task automatic pressButton(input logic [8:0] sw, input logic sel);
      expStrobe_t e;
      e.sel  = sel;
      e.data = {23'b0, sw};
      expQueue.push_back(e);
      applyStimulus(sw, sel, 1'b1);
      waitCycles(10);
      applyStimulus(sw, sel, 1'b0);
      waitCycles(10);
   endtask

   task automatic expectStrobe(input logic [8:0] sw, input logic sel);
      expStrobe_t e;
      e.sel  = sel;
      e.data = {23'b0, sw};
      expQueue.push_back(e);
   endtask

   // The press counter model follows the same reset as the DUT
   always @(posedge rst) modelCount = 0;

   // Monitor: strobe exclusivity, one-cycle width, and scoreboard pop on every strobe
   always @(negedge clk) begin
      if (!rst) begin
         expStrobe_t e;
         if (busy) busySeen = 1'b1;
         checkOutput("strobe_exclusive", {31'b0, inport_0_en & inport_1_en}, 32'd0);
         checkOutput("strobe_one_cycle", {31'b0, prevStrobe & (inport_0_en | inport_1_en)}, 32'd0);
         if (inport_0_en | inport_1_en) begin
            strobeCount++;
            modelCount++;
            if (expQueue.size() == 0) begin
               checkOutput("unexpected_strobe", {31'b0, inport_1_en}, {31'b0, ~inport_1_en});
            end else begin
               e = expQueue.pop_front();
               checkOutput("strobe_port", {31'b0, inport_1_en}, {31'b0, e.sel});
               checkOutput("strobe_data", in_data, e.data);
            end
         end
         prevStrobe = inport_0_en | inport_1_en;
      end else begin
         prevStrobe = 1'b0;
      end
   end

   // Directed sequence
   initial begin
      rst      = 1'b1;
      switches = 9'h000;
      port_sel = 1'b0;
      load_btn = 1'b0;
      #12;
      checkOutput("reset_in_data", in_data, 32'd0);
      checkOutput("reset_en0", {31'b0, inport_0_en}, 32'd0);
      checkOutput("reset_en1", {31'b0, inport_1_en}, 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Held press: strobe lands exactly after edge 7
      expectStrobe(9'h1A5, 1'b0);
      applyStimulus(9'h1A5, 1'b0, 1'b1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("lat_en0_edge6", {31'b0, inport_0_en}, 32'd0);
      checkOutput("lat_busy_edge6", {31'b0, busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("lat_en0_edge7", {31'b0, inport_0_en}, 32'd1);
      checkOutput("lat_en1_edge7", {31'b0, inport_1_en}, 32'd0);
      checkOutput("lat_data_edge7", in_data, 32'h0000_01A5);
      checkOutput("lat_busy_edge7", {31'b0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("lat_en0_edge8", {31'b0, inport_0_en}, 32'd0);
      applyStimulus(9'h1A5, 1'b0, 1'b0);
      waitCycles(12);
      @(negedge clk);
      checkOutput("release_idle_busy", {31'b0, busy}, 32'd0);

      // Port 1 press held for 50 cycles, with switch changes while held
      strobeBefore = strobeCount;
      expectStrobe(9'h003, 1'b1);
      applyStimulus(9'h003, 1'b1, 1'b1);
      waitCycles(10);
      @(negedge clk);
      checkOutput("port1_data", in_data, 32'h0000_0003);
      applyStimulus(9'h0FF, 1'b0, 1'b1);
      waitCycles(50);
      @(negedge clk);
      checkOutput("hold_single_strobe", strobeCount - strobeBefore, 32'd1);
      checkOutput("hold_data_kept", in_data, 32'h0000_0003);
      applyStimulus(9'h0FF, 1'b0, 1'b0);
      waitCycles(12);

      // Short bounces never reach the debounce threshold
      strobeBefore = strobeCount;
      busySeen     = 1'b0;
      repeat (5) begin
         applyStimulus(9'h0FF, 1'b1, 1'b1);
         applyStimulus(9'h0FF, 1'b1, 1'b1);
         applyStimulus(9'h0FF, 1'b1, 1'b0);
         applyStimulus(9'h0FF, 1'b1, 1'b0);
      end
      waitCycles(6);
      @(negedge clk);
      checkOutput("bounce_busy_seen", {31'b0, busySeen}, 32'd1);
      checkOutput("bounce_back_idle", {31'b0, busy}, 32'd0);
      checkOutput("bounce_no_strobe", strobeCount - strobeBefore, 32'd0);
      checkOutput("bounce_data_kept", in_data, 32'h0000_0003);

      // Accepted press, release glitches, then a clean release timed to IDLE
      strobeBefore = strobeCount;
      expectStrobe(9'h155, 1'b0);
      applyStimulus(9'h155, 1'b0, 1'b1);
      waitCycles(10);
      repeat (4) begin
         applyStimulus(9'h155, 1'b0, 1'b0);
         applyStimulus(9'h155, 1'b0, 1'b1);
      end
      applyStimulus(9'h155, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("release_busy_edge6", {31'b0, busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("release_idle_edge7", {31'b0, busy}, 32'd0);
      checkOutput("glitch_single_strobe", strobeCount - strobeBefore, 32'd1);
      checkOutput("glitch_data", in_data, 32'h0000_0155);

      // Reset in PRESS_WAIT at counter 2 aborts the press
      strobeBefore = strobeCount;
      applyStimulus(9'h0AA, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #2;
      checkOutput("prerst_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_data", in_data, 32'd0);
      checkOutput("midrst_en0", {31'b0, inport_0_en}, 32'd0);
      checkOutput("midrst_en1", {31'b0, inport_1_en}, 32'd0);
      checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
      load_btn = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      waitCycles(20);
      @(negedge clk);
      checkOutput("postrst_no_strobe", strobeCount - strobeBefore, 32'd0);
      checkOutput("postrst_data_zero", in_data, 32'd0);
      pressButton(9'h0AA, 1'b1);
      @(negedge clk);
      checkOutput("fresh_press_strobe", strobeCount - strobeBefore, 32'd1);
      checkOutput("fresh_press_data", in_data, 32'h0000_00AA);

`ifdef INPUT_PORT_CTRL_COUNT_EN
      // Wrap the 8-bit press counter
      checkOutput("count_after_reset", {24'b0, press_count}, modelCount);
      for (int i = 0; i < 257; i++) begin
         pressButton(9'(i), i[0]);
      end
      @(negedge clk);
      checkOutput("count_wrap", {24'b0, press_count}, modelCount & 32'hFF);
      checkOutput("count_wrap_value", {24'b0, press_count}, 32'd2);
`endif

      waitCycles(4);
      checkOutput("scoreboard_drained", expQueue.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
